// File: rtl/ksa_share_ctrl.sv
// rtl/ksa_share_ctrl.sv - round-robin sharing of one pipelined Kogge-Stone adder
// Supports single-beat adds at one per cycle and multi-beat chained adds with carry forwarding.
module ksa_share_ctrl #(
   parameter int BITS = 64,
   parameter int NREQ = 4,
   parameter int LAT  = 2,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*BITS-1:0] req_a,
   input  logic [NREQ*BITS-1:0] req_b,
   input  logic [NREQ-1:0]      req_c,
   input  logic [NREQ-1:0]      req_more,
   output logic [BITS-1:0]      add_a,
   output logic [BITS-1:0]      add_b,
   output logic                 add_c,
   input  logic [BITS:0]        add_s,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [BITS:0]        rsp_s,
   output logic                 rsp_last
);

   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {ST_ARB, ST_WAIT, ST_CHAIN} state_t;

   state_t          state;
   logic [IDW-1:0]  rrPtr;
   logic [IDW-1:0]  owner;
   logic [CW-1:0]   waitCnt;
   logic            carryReg;
   logic [LAT-1:0]  tagV;
   logic [LAT-1:0]  tagLast;
   logic [IDW-1:0]  tagId [LAT];

   logic            arbHit;
   logic [IDW-1:0]  arbId;
   logic [IDW-1:0]  idx;
   logic            issue;
   logic [IDW-1:0]  selId;
   logic            selC;
   logic            selMore;
   logic [IDW-1:0]  nextPtr;

   // Search upward from the round-robin pointer, wrapping past NREQ-1.
   always_comb begin
      arbHit = 1'b0;
      arbId  = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(rrPtr) + k) % NREQ);
         if (!arbHit && req_valid[idx]) begin
            arbHit = 1'b1;
            arbId  = idx;
         end
      end
   end

   // During a chain only the owner can issue, and the carry comes from the previous beat.
   always_comb begin
      issue = 1'b0;
      selId = arbId;
      selC  = 1'b0;
      case (state)
         ST_ARB: begin
            issue = arbHit;
            selId = arbId;
            selC  = req_c[arbId];
         end
         ST_CHAIN: begin
            issue = req_valid[owner];
            selId = owner;
            selC  = carryReg;
         end
         default: begin
            issue = 1'b0;
         end
      endcase
      selMore = req_more[selId];
      nextPtr = (selId == IDW'(NREQ - 1)) ? '0 : selId + IDW'(1);
   end

   always_comb begin
      req_ready = '0;
      add_a     = '0;
      add_b     = '0;
      add_c     = 1'b0;
      if (issue) begin
         req_ready[selId] = 1'b1;
         add_a = req_a[int'(selId)*BITS +: BITS];
         add_b = req_b[int'(selId)*BITS +: BITS];
         add_c = selC;
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (tagV[LAT-1]) rsp_valid[tagId[LAT-1]] = 1'b1;
   end

   assign rsp_s    = add_s;
   assign rsp_last = tagV[LAT-1] & tagLast[LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_ARB;
         rrPtr    <= '0;
         owner    <= '0;
         waitCnt  <= '0;
         carryReg <= 1'b0;
         tagV     <= '0;
         tagLast  <= '0;
         for (int i = 0; i < LAT; i++) tagId[i] <= '0;
      end else begin
         // Tag pipeline mirrors the adder latency regardless of FSM state.
         for (int i = LAT - 1; i > 0; i--) begin
            tagV[i]    <= tagV[i-1];
            tagLast[i] <= tagLast[i-1];
            tagId[i]   <= tagId[i-1];
         end
         tagV[0]    <= issue;
         tagLast[0] <= ~selMore;
         tagId[0]   <= selId;

         case (state)
            ST_ARB: begin
               if (issue) begin
                  if (selMore) begin
                     owner   <= selId;
                     waitCnt <= CW'(LAT);
                     state   <= ST_WAIT;
                  end else begin
                     rrPtr <= nextPtr;
                  end
               end
            end
            ST_WAIT: begin
               // Count reaches 1 in the cycle the owner's sum is on add_s.
               if (waitCnt == CW'(1)) begin
                  carryReg <= add_s[BITS];
                  state    <= ST_CHAIN;
               end else begin
                  waitCnt <= waitCnt - CW'(1);
               end
            end
            ST_CHAIN: begin
               if (issue) begin
                  if (selMore) begin
                     waitCnt <= CW'(LAT);
                     state   <= ST_WAIT;
                  end else begin
                     rrPtr <= nextPtr;
                     state <= ST_ARB;
                  end
               end
            end
            default: state <= ST_ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_ksa_share_ctrl.sv
// tb/tb_ksa_share_ctrl.sv - directed self-checking bench for ksa_share_ctrl
// Includes a behavioural two-stage adder so sums are produced independently of the DUT.
module tb_ksa_share_ctrl;
   localparam int BITS = 8;
   localparam int NREQ = 4;
   localparam int LAT  = 2;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*BITS-1:0] req_a = '0;
   logic [NREQ*BITS-1:0] req_b = '0;
   logic [NREQ-1:0]      req_c = '0;
   logic [NREQ-1:0]      req_more = '0;
   logic [BITS-1:0]      add_a;
   logic [BITS-1:0]      add_b;
   logic                 add_c;
   logic [BITS:0]        add_s = '0;
   logic [NREQ-1:0]      rsp_valid;
   logic [BITS:0]        rsp_s;
   logic                 rsp_last;

   int checks = 0;
   int fails  = 0;

   logic [BITS-1:0] aR = '0, bR = '0;
   logic            cR = 1'b0;

   ksa_share_ctrl #(.BITS(BITS), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_more(req_more),
      .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_s(add_s),
      .rsp_valid(rsp_valid), .rsp_s(rsp_s), .rsp_last(rsp_last)
   );

   always #5 clk = ~clk;

   // Operand register then sum register: LAT = 2.
   always @(posedge clk) begin
      aR    <= add_a;
      bR    <= add_b;
      cR    <= add_c;
      add_s <= {1'b0, aR} + {1'b0, bR} + {{BITS{1'b0}}, cR};
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_more = '0;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
      checks++; if (rsp_last !== 1'b0) begin fails++; $display("FAIL reset_rsp_last: got %b expected 0", rsp_last); end
      checks++; if ({add_a, add_b, add_c} !== 17'h0) begin fails++; $display("FAIL reset_add_ops: got %h expected 0", {add_a, add_b, add_c}); end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      reset_dut();
      req_valid = 4'b0001; req_a[7:0] = 8'h0F; req_b[7:0] = 8'h01; req_c[0] = 1'b0; req_more[0] = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
      checks++; if ({add_a, add_b, add_c} !== {8'h0F, 8'h01, 1'b0}) begin fails++; $display("FAIL single_add_ops: got %h/%h/%b expected 0f/01/0", add_a, add_b, add_c); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL single_rsp_early: got %b expected 0000", rsp_valid); end
      checks++; if ({add_a, add_b, add_c} !== 17'h0) begin fails++; $display("FAIL single_idle_ops: got %h expected 0", {add_a, add_b, add_c}); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001) begin fails++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
      checks++; if (rsp_s !== 9'h010) begin fails++; $display("FAIL single_rsp_s: got %h expected 010", rsp_s); end
      checks++; if (rsp_last !== 1'b1) begin fails++; $display("FAIL single_rsp_last: got %b expected 1", rsp_last); end
   endtask

   task automatic test_contention();
      logic [NREQ-1:0] expReady;
      logic [NREQ-1:0] expRsp;
      logic [BITS:0]   expS;
      reset_dut();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*BITS +: BITS] = 8'(8'h10 * i + 1);
         req_b[i*BITS +: BITS] = 8'(i + 2);
      end
      for (int k = 0; k < 6; k++) begin
         req_valid = (k < 4) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         expReady = (k < 4) ? 4'(1 << k) : 4'b0000;
         checks++; if (req_ready !== expReady) begin fails++; $display("FAIL contention_ready c%0d: got %b expected %b", k, req_ready, expReady); end
         if (k >= 2) begin
            expRsp = 4'(1 << (k - 2));
            expS   = 9'(8'h10 * (k - 2) + 1 + (k - 2) + 2);
            checks++; if (rsp_valid !== expRsp) begin fails++; $display("FAIL contention_rsp_valid c%0d: got %b expected %b", k, rsp_valid, expRsp); end
            checks++; if (rsp_s !== expS) begin fails++; $display("FAIL contention_rsp_s c%0d: got %h expected %h", k, rsp_s, expS); end
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_chain_lock();
      reset_dut();
      // cycle 0: requester 1 first beat
      req_valid = 4'b0010; req_a[15:8] = 8'hFF; req_b[15:8] = 8'h01; req_c[1] = 1'b1; req_more[1] = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL chain_beat0_ready: got %b expected 0010", req_ready); end
      checks++; if (add_c !== 1'b1) begin fails++; $display("FAIL chain_beat0_c: got %b expected 1", add_c); end
      next_cycle();
      // cycle 1: second beat offered, requester 0 competes
      req_valid = 4'b0011; req_a[15:8] = 8'h00; req_b[15:8] = 8'h00; req_c[1] = 1'b0; req_more[1] = 1'b0;
      req_a[7:0] = 8'h05; req_b[7:0] = 8'h03; req_more[0] = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL chain_wait1_ready: got %b expected 0000", req_ready); end
      next_cycle();
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL chain_wait2_ready: got %b expected 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0010) begin fails++; $display("FAIL chain_rsp0_valid: got %b expected 0010", rsp_valid); end
      checks++; if (rsp_s !== 9'h101) begin fails++; $display("FAIL chain_rsp0_s: got %h expected 101", rsp_s); end
      checks++; if (rsp_last !== 1'b0) begin fails++; $display("FAIL chain_rsp0_last: got %b expected 0", rsp_last); end
      next_cycle();
      @(negedge clk);
      checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL chain_beat1_ready: got %b expected 0010", req_ready); end
      checks++; if (add_c !== 1'b1) begin fails++; $display("FAIL chain_beat1_c: got %b expected 1", add_c); end
      next_cycle();
      req_valid = 4'b0001;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL lock_release_ready: got %b expected 0001", req_ready); end
      next_cycle();
      req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0010) begin fails++; $display("FAIL chain_rsp1_valid: got %b expected 0010", rsp_valid); end
      checks++; if (rsp_s !== 9'h001) begin fails++; $display("FAIL chain_rsp1_s: got %h expected 001", rsp_s); end
      checks++; if (rsp_last !== 1'b1) begin fails++; $display("FAIL chain_rsp1_last: got %b expected 1", rsp_last); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001 || rsp_s !== 9'h008) begin fails++; $display("FAIL lock_req0_rsp: got %b/%h expected 0001/008", rsp_valid, rsp_s); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_fairness();
      reset_dut();
      req_valid = 4'b0100;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL fair_grant2: got %b expected 0100", req_ready); end
      next_cycle();
      req_valid = 4'b1001;
      @(negedge clk);
      checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL fair_grant3: got %b expected 1000", req_ready); end
      next_cycle();
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL fair_wrap_grant0: got %b expected 0001", req_ready); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      req_valid = 4'b0001; req_a[7:0] = 8'h01; req_b[7:0] = 8'h01;
      next_cycle();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL rstmid_rsp_c1: got %b expected 0000", rsp_valid); end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL rstmid_rsp_c2: got %b expected 0000", rsp_valid); end
      next_cycle();
      req_valid = 4'b1111;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rstmid_rr_zero: got %b expected 0001", req_ready); end
      next_cycle();
      // abandon a chain mid-WAIT
      req_valid = 4'b0100; req_more[2] = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rstmid_chain_start: got %b expected 0100", req_ready); end
      next_cycle();
      req_valid = 4'b0000; req_more = '0;
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      req_valid = 4'b1100;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rstmid_back_to_arb: got %b expected 0100", req_ready); end
      checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL rstmid_no_stale_rsp: got %b expected 0000", rsp_valid); end
      next_cycle();
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_chain_lock();
      test_fairness();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/ksa_share_ctrl.md
Name: ksa_share_ctrl

Overview:
- Round-robin scheduler that shares one pipelined Kogge-Stone adder (operands registered in, sum registered out) among NREQ requesters.
- Accepts single-beat adds back-to-back at one per cycle.
- Supports multi-beat chained adds for wide operands: the carry-out of beat k becomes the carry-in of beat k+1.
- Sits between the requesters and the adder; tracks the owner of every in-flight operation and routes each sum back to it.

Parameters:
- BITS, 64, adder operand width.
- NREQ, 4, number of requesters (2..8).
- LAT, 2, adder latency in cycles from operand drive to sum valid (input register + output register).
- IDW, 2, owner-id width, ceil(log2(NREQ)).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  one-hot accept; a beat transfers when valid&ready.
- req_a  in  NREQ*BITS  operand A, requester i at [i*BITS +: BITS].
- req_b  in  NREQ*BITS  operand B, same packing.
- req_c  in  NREQ  carry-in; used only on the first beat of an operation.
- req_more  in  NREQ  1 = more beats follow (chain continues).
- add_a  out  BITS  operand A to adder.
- add_b  out  BITS  operand B to adder.
- add_c  out  1  carry-in to adder.
- add_s  in  BITS+1  adder sum, valid LAT cycles after issue.
- rsp_valid  out  NREQ  one-hot result strobe.
- rsp_s  out  BITS+1  result, equals add_s.
- rsp_last  out  1  result belongs to the final beat (req_more was 0).

Behaviour:
- Reset (rst_n=0, async):
  - state=ARB, rr pointer=0, tag pipeline valids=0, carry_reg=0.
  - req_ready=0, rsp_valid=0, rsp_last=0.
  - add_a/add_b/add_c=0 whenever nothing is issued.
- Issue: when beat from requester g accepted in cycle t:
  - add_a/add_b/add_c carry g's operands in cycle t; otherwise driven 0.
  - Tag {valid=1, id=g, last=!req_more[g]} enters an LAT-deep shift register.
- Response: in cycle t+LAT, rsp_valid[g]=1, rsp_s=add_s, rsp_last=tag.last. No backpressure; requesters must sink responses.
- FSM:
  - ARB:
    - Grant = first valid requester searching from rr pointer upward, with wrap.
    - req_ready[g]=1 combinationally in the same cycle; ready depends on valid.
    - add_c=req_c[g].
    - If req_more[g]=0: rr pointer=g+1 mod NREQ; stay in ARB, so the next grant can issue the next cycle.
    - If req_more[g]=1: lock owner=g, load wait counter=LAT, go to WAIT.
  - WAIT:
    - req_ready=0 for all requesters.
    - Counter decrements each cycle.
    - In the cycle the owner's tag emerges, carry_reg<=add_s[BITS]; go to CHAIN.
  - CHAIN:
    - Only the owner may be granted. req_ready[owner]=req_valid[owner]; add_c=carry_reg; req_c is ignored.
    - If the owner is not valid, stay in CHAIN indefinitely; other requesters stay starved.
    - On accept with req_more=1: go to WAIT.
    - On accept with req_more=0: rr pointer=owner+1, go to ARB.
- Chained beat spacing: LAT+1 cycles. Single-beat throughput: 1 per cycle.
- Earlier single-beat ops still in flight while WAIT begins complete normally; the tag pipeline is unaffected by FSM state.
- Simultaneous requests: exactly one grant per cycle; req_ready is always one-hot or zero.
- rr pointer wraps NREQ-1 -> 0.
- Reset mid-operation:
  - All tags are discarded; no rsp_valid is produced for in-flight beats, even though the adder still holds stale data.
  - Any chain is abandoned; FSM returns to ARB.

Test Plan (NREQ=4, BITS=8, LAT=2):
- Single add: req_valid=0001, a=0x0F, b=0x01, c=0 at cycle 0 -> req_ready=0001 in cycle 0; rsp_valid=0001, rsp_s=0x010, rsp_last=1 in cycle 2.
- Contention: req_valid=1111 held, all req_more=0, after reset -> grants 0,1,2,3 in cycles 0-3; responses in cycles 2-5, each routed to the matching one-hot rsp_valid.
- Chain: req1 beat0 a=0xFF, b=0x01, c=1, more=1 at cycle 0 -> rsp_s=0x101 in cycle 2, rsp_last=0. Beat1 a=0x00, b=0x00, more=0 -> issued in cycle 3 with add_c=1; rsp_s=0x001, rsp_last=1 in cycle 5.
- Lock: during the chain above, req0 valid from cycle 1 -> req_ready[0]=0 until cycle 4; req0 granted in cycle 4.
- Fairness: after grant to requester 2 with req_valid=1001 -> requester 3 granted first, then requester 0.
- Reset: issue a=0x01, b=0x01 in cycle 0, rst_n=0 in cycle 1 -> no rsp_valid in cycle 2; rr pointer=0; FSM=ARB.
